// File: rtl/mfu_pkg.sv
// Shared definitions for the multi-function unit and its consumers.
package mfu_pkg;

    localparam int unsigned MFU_LANES  = 4;
    localparam int unsigned MFU_LANE_W = 16;
    localparam int unsigned MFU_PSUM_W = MFU_LANE_W + 1;
    localparam int unsigned MFU_MODE_W = 3;
    localparam int unsigned MFU_PROD_W = MFU_LANES * MFU_LANE_W;

    localparam logic [MFU_MODE_W-1:0] MFU_MODE_2X2 = 3'b000;
    localparam logic [MFU_MODE_W-1:0] MFU_MODE_4X4 = 3'b001;
    localparam logic [MFU_MODE_W-1:0] MFU_MODE_8X8 = 3'b010;

    // Sticky status carried alongside an accumulated tile result.
    typedef struct packed {
        logic bad_mode;
        logic overflow;
    } acc_flags_t;

endpackage

// File: rtl/mfu_lane_reduce.sv
// Reduces one 16-bit product slice to a single lane partial sum for the given mode.
module mfu_lane_reduce
    import mfu_pkg::*;
(
    input  logic [MFU_LANE_W-1:0] slice,
    input  logic [MFU_MODE_W-1:0] mode,
    output logic [MFU_PSUM_W-1:0] psum,
    output logic                  bad_mode
);

    // Field sum selected by precision mode; reserved modes contribute nothing.
    always_comb begin
        psum     = '0;
        bad_mode = 1'b0;
        case (mode)
            MFU_MODE_2X2: psum = MFU_PSUM_W'(slice[3:0])  + MFU_PSUM_W'(slice[7:4])
                               + MFU_PSUM_W'(slice[11:8]) + MFU_PSUM_W'(slice[15:12]);
            MFU_MODE_4X4: psum = MFU_PSUM_W'(slice[7:0]) + MFU_PSUM_W'(slice[15:8]);
            MFU_MODE_8X8: psum = MFU_PSUM_W'(slice);
            default:      bad_mode = 1'b1;
        endcase
    end

endmodule

// File: rtl/mfu_accumulator.sv
// Accumulates mfu product beats into four saturating lane sums per tile and
// presents each finished tile through a valid/ready result register.
module mfu_accumulator
    import mfu_pkg::*;
#(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [MFU_PROD_W-1:0]      in_prod,
    input  logic [MFU_MODE_W-1:0]      in_mode,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [MFU_LANES*ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0]           out_beats,
    output logic [1:0]                 out_flags
);

    // One guard bit above whichever is wider: accumulator or partial sum.
    localparam int unsigned SUM_W = ((ACC_W > MFU_PSUM_W) ? ACC_W : MFU_PSUM_W) + 1;

    typedef enum logic [0:0] {
        ACC_IDLE  = 1'b0,
        ACC_ACCUM = 1'b1
    } acc_state_e;

    acc_state_e                        state_q, state_d;
    logic [MFU_MODE_W-1:0]             mode_q, mode_d, eff_mode;
    logic [MFU_LANES-1:0][ACC_W-1:0]   acc_q, acc_d, acc_base, acc_sum;
    logic [MFU_LANES-1:0][SUM_W-1:0]   wide_sum;
    logic [MFU_LANES-1:0][MFU_PSUM_W-1:0] psum;
    logic [MFU_LANES-1:0]              lane_bad, lane_sat;
    logic [CNT_W-1:0]                  cnt_q, cnt_d, cnt_base, cnt_sum;
    acc_flags_t                        flags_q, flags_d, flags_base, flags_sum;

    logic                              out_valid_q, out_valid_d;
    logic [MFU_LANES-1:0][ACC_W-1:0]   out_acc_q, out_acc_d;
    logic [CNT_W-1:0]                  out_beats_q, out_beats_d;
    acc_flags_t                        out_flags_q, out_flags_d;

    logic                              fire;

    assign in_ready  = !out_valid_q || out_ready;
    assign fire      = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_beats = out_beats_q;
    assign out_flags = out_flags_q;

    // A fresh tile uses the offered mode; an open tile keeps the latched one.
    assign eff_mode = (state_q == ACC_IDLE) ? in_mode : mode_q;

    for (genvar g = 0; g < MFU_LANES; g++) begin : g_lane
        mfu_lane_reduce u_reduce (
            .slice    (in_prod[MFU_LANE_W*g +: MFU_LANE_W]),
            .mode     (eff_mode),
            .psum     (psum[g]),
            .bad_mode (lane_bad[g])
        );
    end

    // Running totals including the current beat, starting from zero on a fresh tile.
    always_comb begin
        acc_base   = (state_q == ACC_IDLE) ? '0 : acc_q;
        cnt_base   = (state_q == ACC_IDLE) ? '0 : cnt_q;
        flags_base = (state_q == ACC_IDLE) ? '0 : flags_q;
        wide_sum   = '0;
        lane_sat   = '0;
        acc_sum    = '0;
        for (int unsigned j = 0; j < MFU_LANES; j++) begin
            wide_sum[j] = SUM_W'(acc_base[j]) + SUM_W'(psum[j]);
            lane_sat[j] = |wide_sum[j][SUM_W-1:ACC_W];
            acc_sum[j]  = lane_sat[j] ? '1 : wide_sum[j][ACC_W-1:0];
        end
        cnt_sum            = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
        flags_sum.overflow = flags_base.overflow | (|lane_sat);
        flags_sum.bad_mode = flags_base.bad_mode | (|lane_bad);
    end

    // Next-state: open/extend a tile on each handshake, emit and clear on the last beat.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q && !out_ready;
        out_acc_d   = out_acc_q;
        out_beats_d = out_beats_q;
        out_flags_d = out_flags_q;
        if (fire) begin
            if (in_last) begin
                state_d     = ACC_IDLE;
                acc_d       = '0;
                cnt_d       = '0;
                flags_d     = '0;
                out_valid_d = 1'b1;
                out_acc_d   = acc_sum;
                out_beats_d = cnt_sum;
                out_flags_d = flags_sum;
            end else begin
                state_d = ACC_ACCUM;
                mode_d  = eff_mode;
                acc_d   = acc_sum;
                cnt_d   = cnt_sum;
                flags_d = flags_sum;
            end
        end
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACC_IDLE;
            mode_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_beats_q <= '0;
            out_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_beats_q <= out_beats_d;
            out_flags_q <= out_flags_d;
        end
    end

endmodule

// File: tb/tb_mfu_accumulator.sv
// Scoreboard bench for mfu_accumulator: two instances (32-bit/16-bit lanes,
// 16-bit/4-bit beat counters) share one stimulus stream.
module tb_mfu_accumulator;

    localparam longint MAX_A = 64'd4294967295;
    localparam longint MAX_B = 64'd65535;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [63:0]  in_prod = '0;
    logic [2:0]   in_mode = '0;
    logic         in_last = 1'b0;
    logic         out_ready = 1'b1;

    logic         in_ready_a, in_ready_b, out_valid_a, out_valid_b;
    logic [127:0] out_acc_a;
    logic [63:0]  out_acc_b;
    logic [15:0]  out_beats_a;
    logic [3:0]   out_beats_b;
    logic [1:0]   out_flags_a, out_flags_b;

    typedef struct {
        logic [127:0] acc_a;
        logic [63:0]  acc_b;
        logic [15:0]  beats_a;
        logic [3:0]   beats_b;
        logic [1:0]   fl_a;
        logic [1:0]   fl_b;
    } exp_t;

    exp_t       sb[$];
    longint     m_sum[4];
    int         m_beats = 0;
    logic       m_bad = 1'b0;
    logic       m_open = 1'b0;
    logic [2:0] m_mode = '0;
    logic       rdy_s = 1'b0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    mfu_accumulator #(.ACC_W(32), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_prod(in_prod), .in_mode(in_mode), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_acc(out_acc_a),
        .out_beats(out_beats_a), .out_flags(out_flags_a)
    );

    mfu_accumulator #(.ACC_W(16), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_prod(in_prod), .in_mode(in_mode), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_acc(out_acc_b),
        .out_beats(out_beats_b), .out_flags(out_flags_b)
    );

    function automatic longint part_sum(input logic [15:0] s, input logic [2:0] m);
        case (m)
            3'd0: return longint'(s[3:0]) + longint'(s[7:4]) + longint'(s[11:8]) + longint'(s[15:12]);
            3'd1: return longint'(s[7:0]) + longint'(s[15:8]);
            3'd2: return longint'(s);
            default: return 0;
        endcase
    endfunction

    // Reference model: updated on each accepted beat, pushes a result on the last one.
    task automatic model_beat(input logic [63:0] p, input logic [2:0] m, input logic last);
        exp_t e;
        logic ov_a, ov_b;
        if (!m_open) begin
            m_open = 1'b1; m_mode = m; m_beats = 0; m_bad = 1'b0;
            for (int j = 0; j < 4; j++) m_sum[j] = 0;
        end
        for (int j = 0; j < 4; j++) m_sum[j] += part_sum(p[16*j +: 16], m_mode);
        m_beats++;
        if (m_mode > 3'd2) m_bad = 1'b1;
        if (last) begin
            ov_a = 1'b0; ov_b = 1'b0;
            for (int j = 0; j < 4; j++) begin
                if (m_sum[j] > MAX_A) begin e.acc_a[32*j +: 32] = '1; ov_a = 1'b1; end
                else e.acc_a[32*j +: 32] = 32'(m_sum[j]);
                if (m_sum[j] > MAX_B) begin e.acc_b[16*j +: 16] = '1; ov_b = 1'b1; end
                else e.acc_b[16*j +: 16] = 16'(m_sum[j]);
            end
            e.beats_a = (m_beats > 65535) ? 16'hFFFF : 16'(m_beats);
            e.beats_b = (m_beats > 15) ? 4'hF : 4'(m_beats);
            e.fl_a = {m_bad, ov_a};
            e.fl_b = {m_bad, ov_b};
            sb.push_back(e);
            m_open = 1'b0;
        end
    endtask

    // Pops and compares whenever a result is accepted downstream.
    task automatic sb_check();
        exp_t e;
        if (rst_n && out_valid_a && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++; $display("FAIL sb_empty got out_valid=1 exp no pending result");
            end else begin
                e = sb.pop_front();
                checks++; if (out_acc_a !== e.acc_a) begin errors++; $display("FAIL acc_a got %h exp %h", out_acc_a, e.acc_a); end
                checks++; if (out_acc_b !== e.acc_b) begin errors++; $display("FAIL acc_b got %h exp %h", out_acc_b, e.acc_b); end
                checks++; if (out_beats_a !== e.beats_a) begin errors++; $display("FAIL beats_a got %0d exp %0d", out_beats_a, e.beats_a); end
                checks++; if (out_beats_b !== e.beats_b) begin errors++; $display("FAIL beats_b got %0d exp %0d", out_beats_b, e.beats_b); end
                checks++; if (out_flags_a !== e.fl_a) begin errors++; $display("FAIL flags_a got %b exp %b", out_flags_a, e.fl_a); end
                checks++; if (out_flags_b !== e.fl_b) begin errors++; $display("FAIL flags_b got %b exp %b", out_flags_b, e.fl_b); end
                checks++; if (out_valid_b !== 1'b1) begin errors++; $display("FAIL valid_b got %b exp 1", out_valid_b); end
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        rdy_s = in_ready_a;
        sb_check();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Offers one beat and waits (bounded) for its handshake.
    task automatic beat(input logic [63:0] p, input logic [2:0] m, input logic last);
        int n;
        in_valid = 1'b1; in_prod = p; in_mode = m; in_last = last;
        n = 0;
        forever begin
            sample();
            advance();
            n++;
            if (rdy_s || n >= 200) break;
        end
        checks++;
        if (!rdy_s) begin
            errors++; $display("FAIL beat_timeout got in_ready=0 for %0d cycles exp handshake", n);
        end else begin
            model_beat(p, m, last);
        end
        in_valid = 1'b0;
    endtask

    task automatic model_clear();
        sb.delete();
        m_open = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) advance();
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid_a); end
        checks++; if (out_acc_a !== '0) begin errors++; $display("FAIL rst_acc got %h exp 0", out_acc_a); end
        checks++; if (out_beats_a !== '0) begin errors++; $display("FAIL rst_beats got %0d exp 0", out_beats_a); end
        checks++; if (out_flags_a !== '0) begin errors++; $display("FAIL rst_flags got %b exp 0", out_flags_a); end
        rst_n = 1'b1;
        advance();
        checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready_a); end
    endtask

    task automatic test_mode_2x2();
        beat({16{4'b0100}}, 3'd0, 1'b1);
        sample();
        checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL m2x2_latency got %b exp 1", out_valid_a); end
        checks++; if (out_acc_a !== {4{32'd16}}) begin errors++; $display("FAIL m2x2_acc got %h exp lanes of 16", out_acc_a); end
        advance();
    endtask

    task automatic test_mode_4x4();
        for (int i = 0; i < 3; i++) beat({8{8'd225}}, 3'd1, (i == 2) ? 1'b1 : 1'b0);
        sample();
        checks++; if (out_acc_a !== {4{32'd1350}}) begin errors++; $display("FAIL m4x4_acc got %h exp lanes of 1350", out_acc_a); end
        checks++; if (out_beats_a !== 16'd3) begin errors++; $display("FAIL m4x4_beats got %0d exp 3", out_beats_a); end
        advance();
    endtask

    task automatic test_mode_latch_and_sat();
        beat({4{16'hFFFF}}, 3'd2, 1'b0);
        beat({4{16'hFFFF}}, 3'd0, 1'b1);
        sample();
        checks++; if (out_acc_a !== {4{32'd131070}}) begin errors++; $display("FAIL latch_acc got %h exp lanes of 131070", out_acc_a); end
        checks++; if (out_acc_b !== {4{16'd65535}}) begin errors++; $display("FAIL sat_acc got %h exp lanes of 65535", out_acc_b); end
        checks++; if (out_flags_b !== 2'b01) begin errors++; $display("FAIL sat_flag got %b exp 01", out_flags_b); end
        advance();
        beat({4{16'h0001}}, 3'd2, 1'b1);
        sample();
        checks++; if (out_flags_b !== 2'b00) begin errors++; $display("FAIL sat_flag_clear got %b exp 00", out_flags_b); end
        advance();
    endtask

    task automatic test_bad_mode();
        beat('1, 3'd5, 1'b1);
        sample();
        checks++; if (out_acc_a !== '0) begin errors++; $display("FAIL bad_acc got %h exp 0", out_acc_a); end
        checks++; if (out_flags_a !== 2'b10) begin errors++; $display("FAIL bad_flag got %b exp 10", out_flags_a); end
        advance();
    endtask

    task automatic test_cnt_sat();
        for (int i = 0; i < 20; i++) beat(64'h1111_1111_1111_1111, 3'd0, (i == 19) ? 1'b1 : 1'b0);
        sample();
        checks++; if (out_beats_b !== 4'd15) begin errors++; $display("FAIL cnt_sat got %0d exp 15", out_beats_b); end
        checks++; if (out_beats_a !== 16'd20) begin errors++; $display("FAIL cnt_a got %0d exp 20", out_beats_a); end
        checks++; if (out_flags_b !== 2'b00) begin errors++; $display("FAIL cnt_flags got %b exp 00", out_flags_b); end
        advance();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        beat(64'h0001_0002_0003_0004, 3'd2, 1'b1);
        in_valid = 1'b1; in_prod = 64'h0010_0020_0030_0040; in_mode = 3'd2; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", in_ready_a); end
            checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", out_valid_a); end
            checks++; if (out_acc_a !== {32'd1, 32'd2, 32'd3, 32'd4}) begin errors++; $display("FAIL bp_hold got %h exp 00000001000000020000000300000004", out_acc_a); end
            checks++; if (sb.size() !== 1) begin errors++; $display("FAIL bp_pending got %0d exp 1", sb.size()); end
            advance();
        end
        out_ready = 1'b1;
        beat(64'h0010_0020_0030_0040, 3'd2, 1'b1);
        sample();
        checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", out_valid_a); end
        checks++; if (out_acc_a !== {32'h10, 32'h20, 32'h30, 32'h40}) begin errors++; $display("FAIL b2b_acc got %h exp second tile", out_acc_a); end
        advance();
    endtask

    task automatic test_reset_midtile();
        out_ready = 1'b0;
        beat(64'h1234_5678_9ABC_DEF0, 3'd0, 1'b0);
        beat(64'h1111_2222_3333_4444, 3'd0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL mrst_valid got %b exp 0", out_valid_a); end
        checks++; if (out_acc_a !== '0 || out_acc_b !== '0) begin errors++; $display("FAIL mrst_acc got %h/%h exp 0", out_acc_a, out_acc_b); end
        checks++; if (out_beats_a !== '0 || out_flags_a !== '0) begin errors++; $display("FAIL mrst_misc got %0d/%b exp 0/00", out_beats_a, out_flags_a); end
        model_clear();
        advance();
        rst_n = 1'b1;
        out_ready = 1'b1;
        beat({4{16'hFFFF}}, 3'd1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL mrst2_valid got %b exp 0", out_valid_a); end
        advance();
        rst_n = 1'b1;
        beat({4{16'h0102}}, 3'd1, 1'b1);
        sample();
        checks++; if (out_acc_a !== {4{32'd3}}) begin errors++; $display("FAIL mrst_discard got %h exp lanes of 3", out_acc_a); end
        advance();
    endtask

    task automatic test_random();
        int len;
        for (int t = 0; t < 30; t++) begin
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid_a && !out_ready) begin
                    sample();
                    advance();
                end
                out_ready = 1'b1;
                beat({$urandom, $urandom}, 3'($urandom_range(0, 5)), (b == len - 1) ? 1'b1 : 1'b0);
            end
        end
        out_ready = 1'b1;
        repeat (3) begin sample(); advance(); end
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL drain got %0d pending exp 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_mode_2x2();
        test_mode_4x4();
        test_mode_latch_and_sat();
        test_bad_mode();
        test_cnt_sat();
        test_back_to_back();
        test_reset_midtile();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mfu_accumulator.md
# mfu_accumulator

Consumer-side block for the multi-function unit (mfu) in the sparse DNN datapath. It accepts the mfu's 64-bit packed product vector each beat and reduces it into four per-lane partial sums, interpreting the packing according to the precision mode. It accumulates those sums over a tile of beats delimited by `in_last`. It hands a 4-lane accumulated result downstream through a valid/ready register.

## Interface
- `ACC_W`, default 32: per-lane accumulator width, unsigned.
- `CNT_W`, default 16: beat-counter width.
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: reset, asynchronous assert, active-low (already decided).
- `in_valid`, input, 1: product beat valid.
- `in_ready`, output, 1: block can take a beat.
- `in_prod`, input, 64: packed unsigned products straight from mfu `o`.
- `in_mode`, input, 3: mfu mode for this tile.
- `in_last`, input, 1: final beat of the tile.
- `out_valid`, output, 1: result register full.
- `out_ready`, input, 1: downstream accepts the result.
- `out_acc`, output, 4*ACC_W: lane j occupies `[ACC_W*j +: ACC_W]`.
- `out_beats`, output, CNT_W: beats in the tile, saturating.
- `out_flags`, output, 2: bit0 is sticky overflow, bit1 is sticky bad-mode.

## Operation
- Lane j owns bits `in_prod[16j+15:16j]`.
- Per-beat lane partial sum by mode:
  - Mode 000 (2x2): sum of the four 4-bit fields.
  - Mode 001 (4x4): sum of the two 8-bit fields.
  - Mode 010 (8x8): the single 16-bit field.
  - Modes 011–111 are reserved: the partial sum is 0 and bad-mode is set.
- Partial sums are zero-extended to ACC_W before adding. Each lane saturates at 2^ACC_W−1, and any saturation sets overflow.
- FSM states:
  - IDLE (no tile open): on a beat handshake, latch `in_mode` and load acc = partial sum. Go to ACCUM, or if `in_last`, go straight to emit.
  - ACCUM: `in_mode` is ignored and the latched mode is used. Each handshake adds to acc. A handshake with `in_last` emits and returns to IDLE.
- Emit, on the handshake edge of the last beat:
  - `out_acc` ← acc + this beat's partial sum.
  - `out_beats` ← count including this beat.
  - `out_flags` ← sticky flags including this beat.
  - `out_valid` ← 1.
  - Internal acc, count and flags clear.
- A single-beat tile is legal: first beat and last beat on the same handshake.
- Beat counter saturates at 2^CNT_W−1. Saturation of the counter does not set any flag.

## Timing
- Reset values:
  - `out_valid`=0, `out_acc`=0, `out_beats`=0, `out_flags`=0.
  - State = IDLE; internal acc, count and flags = 0.
  - `in_ready`=1 once reset releases.
- `in_ready = !out_valid || out_ready`. It is combinational on `out_ready` only and never depends on `in_valid`.
- A beat is consumed on a rising edge with `in_valid && in_ready`. A beat offered while `in_ready`=0 must be held by the sender.
- Result latency is 1 edge: `out_valid` is high in the cycle after the last-beat handshake.
- `out_valid && out_ready` with no new emit: `out_valid` falls on that edge.
- Simultaneous result accept and new last-beat emit on the same edge: the register reloads and `out_valid` stays 1 with no bubble.
- Outputs are stable while `out_valid && !out_ready`.
- Reset asserted mid-tile: partial acc is discarded, the pending result is dropped, and all outputs return to their reset values immediately.

## Structure
- Shared package `mfu_pkg` holds:
  - Mode encodings `MFU_MODE_2X2`, `MFU_MODE_4X4`, `MFU_MODE_8X8`.
  - Lane count 4 and lane slice width 16.
  - This package is shared with the mfu itself.
- Sub-module `mfu_lane_reduce`:
  - Purely combinational: one 16-bit slice plus mode in, 17-bit partial sum plus bad-mode out.
  - Instantiated 4×.
- Top holds the FSM, accumulators, counter, flags and output register.

## Test plan
- Mode 000, one beat, `in_prod`={16{4'b0100}}, `in_last`=1 -> next cycle `out_valid`=1, every lane is 16, `out_beats`=1, `out_flags`=0.
- Mode 001, 3 beats of `in_prod`={8{8'd225}}, last on beat 3 -> each lane is 1350, `out_beats`=3.
- Mode 010, tile opened in 010 and then `in_mode` switched to 000 mid-tile, 2 beats of {4{16'hFFFF}} -> latched mode 010 is used throughout, each lane is 131070.
- ACC_W=16, mode 010, 2 beats of {4{16'hFFFF}} -> each lane is 65535, `out_flags[0]`=1. The next tile starts with flags clear.
- Mode 101, one beat, `in_prod`=all-ones -> each lane is 0, `out_flags[1]`=1.
- Backpressure:
  - With `out_ready`=0 after an emit, `in_ready` is 0, the offered beat is held, and outputs are unchanged.
  - Raising `out_ready` together with a new last beat gives back-to-back results with `out_valid` continuously 1.
  - A reset pulse mid-tile clears all outputs to 0.
